uart_alu_host: RTL and testbench

UART_ALU_HOST -- requirements
Module: uart_alu_host

---
 rtl/uart_alu_host.sv | 127 ++++++++++++
 tb/tb_uart_alu_host.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_host.sv
// uart_alu_host: sends an ALU command (opcode, val1, val2) as three bytes
// into a TX FIFO, then waits for one result byte from an RX FIFO.
//
// Ports:
//   i_clock, i_reset        clock, async active-high reset
//   i_start, o_ready        command request, accepted only while idle
//   i_opc, i_val1, i_val2   command fields
//   i_tx_full, o_wr,        TX FIFO full flag, write strobe, write data
//   o_wdata
//   i_rx_empty, i_rx_data,  RX FIFO (first-word fall-through), pop strobe
//   o_rd
//   o_result, o_done,       last result, capture pulse, timeout pulse
//   o_timeout
module uart_alu_host #(
  parameter int N       = 8,
  parameter int OPC_N   = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [OPC_N-1:0] i_opc,
  input  logic [N-1:0]     i_val1,
  input  logic [N-1:0]     i_val2,
  input  logic             i_tx_full,
  output logic             o_wr,
  output logic [N-1:0]     o_wdata,
  input  logic             i_rx_empty,
  input  logic [N-1:0]     i_rx_data,
  output logic             o_rd,
  output logic             o_ready,
  output logic [N-1:0]     o_result,
  output logic             o_done,
  output logic             o_timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_OPC,
    SEND_OP1,
    SEND_OP2,
    WAIT_RESP
  } state_t;

  state_t        state;
  logic          wr_q;
  logic [N-1:0]  wdata_q;
  logic [N-1:0]  val1_q;
  logic [N-1:0]  val2_q;
  logic [CW-1:0] cnt;

  // wr_q is high in every SEND state; the strobe is masked while the
  // FIFO is full and the state holds, so the same byte is retried.
  assign o_wr    = wr_q & ~i_tx_full;
  assign o_wdata = wdata_q;
  assign o_ready = (state == IDLE);

  // wdata_q doubles as the latched opcode: it is loaded with the
  // zero-extended opcode on accept and stepped through the operands.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      cnt       <= '0;
      o_rd      <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_result  <= '0;
    end else begin
      o_rd      <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            wdata_q <= N'(i_opc);
            val1_q  <= i_val1;
            val2_q  <= i_val2;
            wr_q    <= 1'b1;
            state   <= SEND_OPC;
          end
        end
        SEND_OPC: begin
          if (!i_tx_full) begin
            wdata_q <= val1_q;
            state   <= SEND_OP1;
          end
        end
        SEND_OP1: begin
          if (!i_tx_full) begin
            wdata_q <= val2_q;
            state   <= SEND_OP2;
          end
        end
        SEND_OP2: begin
          if (!i_tx_full) begin
            wr_q  <= 1'b0;
            cnt   <= '0;
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // Data wins over an expiring counter in the same cycle.
          if (!i_rx_empty) begin
            o_result <= i_rx_data;
            o_rd     <= 1'b1;
            o_done   <= 1'b1;
            state    <= IDLE;
          end else if (cnt == CNT_MAX) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
// tb_uart_alu_host: scoreboard bench with a remote-ALU responder,
// TX/RX FIFO models, directed corner cases and random commands.
module tb_uart_alu_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset;
  logic       i_start;
  logic [5:0] i_opc;
  logic [7:0] i_val1;
  logic [7:0] i_val2;
  logic       i_tx_full;
  logic       o_wr;
  logic [7:0] o_wdata;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rd;
  logic       o_ready;
  logic [7:0] o_result;
  logic       o_done;
  logic       o_timeout;

  uart_alu_host #(
    .N(8),
    .OPC_N(6),
    .TIMEOUT(16)
  ) dut (
    .i_clock   (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_opc     (i_opc),
    .i_val1    (i_val1),
    .i_val2    (i_val2),
    .i_tx_full (i_tx_full),
    .o_wr      (o_wr),
    .o_wdata   (o_wdata),
    .i_rx_empty(i_rx_empty),
    .i_rx_data (i_rx_data),
    .o_rd      (o_rd),
    .o_ready   (o_ready),
    .o_result  (o_result),
    .o_done    (o_done),
    .o_timeout (o_timeout)
  );

  typedef struct {
    bit         to;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    int         due;
    logic [7:0] val;
  } rsp_t;

  exp_t       sb[$];
  logic [7:0] exp_bytes[$];
  int         plan[$];
  rsp_t       pend[$];
  logic [7:0] rxq[$];
  logic [7:0] frame[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wcyc = -1;
  int wr_count = 0;
  int stall_req = 0;
  int stall_left = 0;
  bit rnd_full = 1'b0;
  logic [7:0] last_result = 8'h00;

  exp_t env_e;
  rsp_t env_rt;
  int   env_d;
  bit   env_resume;

  // Remote ALU behaviour: what the far end answers for a command.
  function automatic logic [7:0] alu(input logic [7:0] op,
                                     input logic [7:0] a,
                                     input logic [7:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // FIFO models, responder and monitor.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (wcyc >= 0) wcyc++;
      if (i_reset) begin
        exp_bytes.delete();
        sb.delete();
        plan.delete();
        rxq.delete();
        pend.delete();
        frame.delete();
        wcyc       = -1;
        stall_left = 0;
        i_tx_full  = 1'b0;
        i_rx_empty = 1'b1;
        i_rx_data  = 8'h00;
        continue;
      end
      if (o_rd && rxq.size() > 0) void'(rxq.pop_front());
      else if (o_rd) begin
        checks++;
        errors++;
        $display("FAIL rd_empty_fifo o_rd=%0b want 0", o_rd);
      end
      while (pend.size() > 0 && pend[0].due <= cyc)
        rxq.push_back(pend.pop_front().val);
      i_rx_empty = (rxq.size() == 0);
      i_rx_data  = i_rx_empty ? 8'($urandom) : rxq[0];
      env_resume = 1'b0;
      if (stall_left > 1) i_tx_full = 1'b1;
      else if (stall_left == 1) begin
        i_tx_full  = 1'b0;
        env_resume = 1'b1;
      end else i_tx_full = rnd_full && ($urandom_range(0, 3) == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (env_resume) chk("bp_resume_wr", o_wr, 1);
      if (o_wr) begin
        chk("wr_while_full", i_tx_full, 0);
        if (exp_bytes.size() > 0)
          chk("wr_byte", o_wdata, exp_bytes.pop_front());
        else begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected data %h want none", o_wdata);
        end
        frame.push_back(o_wdata);
        wr_count++;
        if (frame.size() == 1 && stall_req > 0) begin
          stall_left = stall_req + 1;
          stall_req  = 0;
        end
        if (frame.size() == 3) begin
          env_d = (plan.size() > 0) ? plan.pop_front() : -1;
          if (env_d >= 0) begin
            env_rt.due = cyc + 1 + env_d;
            env_rt.val = alu(frame[0], frame[1], frame[2]);
            pend.push_back(env_rt);
          end
          frame.delete();
          wcyc = 0;
        end
      end
      if (o_done || o_timeout) begin
        if (sb.size() > 0) begin
          env_e = sb.pop_front();
          chk("resp_timeout", o_timeout, env_e.to);
          chk("resp_done", o_done, !env_e.to);
          chk("result", o_result, env_e.val);
          chk("rd_with_done", o_rd, !env_e.to);
          if (env_e.to) chk("timeout_latency", wcyc, 17);
        end else begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected done=%0b timeout=%0b want none",
                   o_done, o_timeout);
        end
        wcyc = -1;
      end else if (o_rd) begin
        checks++;
        errors++;
        $display("FAIL rd_stray o_rd=%0b want 0", o_rd);
      end
    end
  end

  task automatic issue(input logic [5:0] opc,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input int d);
    int n;
    exp_t e;
    logic [7:0] r;
    n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait ready=%0b want 1", o_ready);
      return;
    end
    r = alu({2'b00, opc}, a, b);
    exp_bytes.push_back({2'b00, opc});
    exp_bytes.push_back(a);
    exp_bytes.push_back(b);
    plan.push_back(d);
    if (d < 0) begin
      e.to  = 1'b1;
      e.val = last_result;
    end else begin
      e.to  = 1'b0;
      e.val = r;
      last_result = r;
    end
    sb.push_back(e);
    i_start = 1'b1;
    i_opc   = opc;
    i_val1  = a;
    i_val2  = b;
    @(negedge clk);
    // Busy now: a second request with other values must be ignored.
    i_opc  = ~opc;
    i_val1 = ~a;
    i_val2 = ~b;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    #2;
    while ((sb.size() != 0 || !o_ready) && n < lim) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("idle_reached", (sb.size() == 0) && o_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int d;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_opc      = 6'h00;
    i_val1     = 8'h00;
    i_val2     = 8'h00;
    i_tx_full  = 1'b0;
    i_rx_empty = 1'b1;
    i_rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wr", o_wr, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_done", o_done, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_result", o_result, 0);
    i_reset = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1);

    // Basic command, result 8'h08.
    issue(6'h20, 8'h05, 8'h03, 2);
    wait_idle(100);
    chk("basic_result", o_result, 8'h08);

    // TX FIFO full for four cycles after the opcode byte.
    stall_req = 4;
    issue(6'h21, 8'h40, 8'h11, 1);
    wait_idle(100);

    // No response: timeout keeps the previous result.
    issue(6'h22, 8'h0f, 8'hf0, -1);
    wait_idle(100);
    chk("timeout_keeps", o_result, 8'h2f);

    // Reset after the val1 byte.
    base = wr_count;
    issue(6'h2a, 8'h11, 8'h22, -1);
    n = 0;
    #2;
    while (wr_count < base + 2 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("mid_val1_seen", wr_count - base, 2);
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    #1;
    chk("mid_rst_wr", o_wr, 0);
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    last_result = 8'h00;
    #1;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_result", o_result, 0);
    base = wr_count;
    issue(6'h03, 8'hc3, 8'h5a, 0);
    wait_idle(100);
    chk("post_rst_writes", wr_count - base, 3);

    // Back-to-back commands.
    base = wr_count;
    issue(6'h01, 8'h09, 8'h04, 0);
    issue(6'h02, 8'h3c, 8'h0f, 3);
    wait_idle(100);
    chk("b2b_writes", wr_count - base, 6);
    chk("b2b_result", o_result, 8'h33);

    // Random commands with random TX backpressure.
    rnd_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 10));
      issue(6'($urandom), 8'($urandom), 8'($urandom), d);
    end
    wait_idle(1000);
    chk("bytes_left", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
